// File: rtl/hzu_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hzu_scoreboard_pkg
// Description : Shared types and decode helpers for the hazard scoreboard.
//               Thread/register ids, opcode and latency-class enums,
//               instruction layout, and opcode-to-operand-usage functions.
// Revision    : 1.0 - initial release
// ============================================================================
package hzu_scoreboard_pkg;

    localparam int NTHREADS = 4;
    localparam int NREGS    = 32;
    localparam int TID_W    = $clog2(NTHREADS);
    localparam int RID_W    = $clog2(NREGS);

    typedef logic [TID_W-1:0] threadid_t;
    typedef logic [RID_W-1:0] regid_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_ADDI = 4'd3,
        OP_MOV  = 4'd4,
        OP_MUL  = 4'd5,
        OP_LDB  = 4'd6,
        OP_LDW  = 4'd7,
        OP_STW  = 4'd8,
        OP_BEQ  = 4'd9
    } opcode_t;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_MUL  = 2'd1,
        LAT_MEM  = 2'd2,
        LAT_NONE = 2'd3
    } lat_class_t;

    // Register-format fields
    typedef struct packed {
        regid_t dst;
        regid_t src1;
        regid_t src2;
    } rfields_t;

    // Immediate-format fields share the slot used by src2
    typedef struct packed {
        regid_t             dst;
        regid_t             src1;
        logic [RID_W-1:0]   imm;
    } ifields_t;

    typedef union packed {
        rfields_t r;
        ifields_t i;
    } fields_t;

    typedef struct packed {
        opcode_t op;
        fields_t fields;
    } instr_t;

    function automatic lat_class_t lat_class(opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_MOV: return LAT_ALU;
            OP_MUL:                          return LAT_MUL;
            OP_LDB, OP_LDW:                  return LAT_MEM;
            default:                         return LAT_NONE;
        endcase
    endfunction

    // Loads and stores use src1 as the address base
    function automatic logic has_src1(opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_MOV, OP_MUL,
            OP_LDB, OP_LDW, OP_STW, OP_BEQ: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Stores read their data register through src2
    function automatic logic has_src2(opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_STW, OP_BEQ: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic has_dst(opcode_t op);
        return lat_class(op) != LAT_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hzu_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hzu_scoreboard_if
// Description : Decode/issue, load-writeback and flush bundle of the hazard
//               scoreboard. master = instruction/control source,
//               slave = scoreboard.
//   valid_in/thread/instr/fetch_miss : decoded instruction slot
//   wb_en/wb_thread/wb_reg           : load writeback release
//   flush_en/flush_thread            : per-thread squash
//   issue_ok/hazard_src              : combinational issue decision
//   busy_threads                     : registered per-thread pending flag
// Revision    : 1.0 - initial release
// ============================================================================
interface hzu_scoreboard_if;
    import hzu_scoreboard_pkg::*;

    logic                valid_in;
    threadid_t           thread;
    instr_t              instr;
    logic                fetch_miss;
    logic                wb_en;
    threadid_t           wb_thread;
    regid_t              wb_reg;
    logic                flush_en;
    threadid_t           flush_thread;
    logic                issue_ok;
    logic [1:0]          hazard_src;
    logic [NTHREADS-1:0] busy_threads;

    modport master (
        output valid_in, thread, instr, fetch_miss,
        output wb_en, wb_thread, wb_reg, flush_en, flush_thread,
        input  issue_ok, hazard_src, busy_threads
    );

    modport slave (
        input  valid_in, thread, instr, fetch_miss,
        input  wb_en, wb_thread, wb_reg, flush_en, flush_thread,
        output issue_ok, hazard_src, busy_threads
    );
endinterface
`default_nettype wire

// File: rtl/hzu_scoreboard_sb_bank.sv
`default_nettype none
// ============================================================================
// Module      : hzu_sb_bank
// Description : One thread's NREGS x CNT_W countdown array.
//   clk, rst               : clock, async active-high reset
//   dec_en                 : age all timed counters by one
//   clr_all                : zero every counter (thread flush)
//   clr_ld_en/clr_ld_idx   : zero one counter if it holds LD_PEND
//   set_en/set_idx/set_val : load one counter (issue)
//   rd{1,2,3}_idx/_cnt     : three asynchronous read ports
//   busy                   : registered OR of all counters after update
// Revision    : 1.0 - initial release
// ============================================================================
module hzu_sb_bank
    import hzu_scoreboard_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             dec_en,
    input  wire logic             clr_all,
    input  wire logic             clr_ld_en,
    input  wire regid_t           clr_ld_idx,
    input  wire logic             set_en,
    input  wire regid_t           set_idx,
    input  wire logic [CNT_W-1:0] set_val,
    input  wire regid_t           rd1_idx,
    input  wire regid_t           rd2_idx,
    input  wire regid_t           rd3_idx,
    output logic      [CNT_W-1:0] rd1_cnt,
    output logic      [CNT_W-1:0] rd2_cnt,
    output logic      [CNT_W-1:0] rd3_cnt,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] LD_PEND = '1;

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic             busy_q;
    logic             busy_d;

    // Update order: age, load release, flush, issue; later steps win.
    always_comb begin
        busy_d = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            // LD_PEND has no timeout: it waits for writeback or flush
            if (dec_en && cnt_q[r] != '0 && cnt_q[r] != LD_PEND)
                cnt_d[r] = cnt_q[r] - 1'b1;
            if (clr_ld_en && clr_ld_idx == regid_t'(r) && cnt_q[r] == LD_PEND)
                cnt_d[r] = '0;
            if (clr_all)
                cnt_d[r] = '0;
            if (set_en && set_idx == regid_t'(r))
                cnt_d[r] = set_val;
            busy_d = busy_d | (|cnt_d[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                cnt_q[r] <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                cnt_q[r] <= cnt_d[r];
            busy_q <= busy_d;
        end
    end

    assign rd1_cnt = cnt_q[rd1_idx];
    assign rd2_cnt = cnt_q[rd2_idx];
    assign rd3_cnt = cnt_q[rd3_idx];
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: rtl/hzu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hzu_scoreboard
// Description : Multi-thread decode/issue hazard unit. Tracks pending
//               destination writes per (thread, register) and decides in the
//               same cycle whether the decoded instruction may issue.
//   clk, rst : clock, async active-high reset
//   sb       : hzu_scoreboard_if.slave (instruction, writeback, flush in;
//              issue_ok, hazard_src, busy_threads out)
// Revision    : 1.0 - initial release
// ============================================================================
module hzu_scoreboard
    import hzu_scoreboard_pkg::*;
#(
    parameter int ALU_LAT   = 5,
    parameter int MUL_LAT   = 9,
    parameter int BYPASS_EN = 0,
    parameter int ZERO_REG  = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    hzu_scoreboard_if.slave sb
);

    localparam int               CNT_W   = $clog2(MUL_LAT + 2);
    localparam logic [CNT_W-1:0] LD_PEND = '1;
    // A counter holds the number of cycles, counted from the cycle after
    // issue, that a reader must still wait. The issue cycle itself is one of
    // the LAT cycles, hence LAT-1.
    localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0]    rd1_cnt [NTHREADS];
    logic [CNT_W-1:0]    rd2_cnt [NTHREADS];
    logic [CNT_W-1:0]    rd3_cnt [NTHREADS];
    logic [NTHREADS-1:0] bank_busy;

    opcode_t          op;
    regid_t           src1;
    regid_t           src2;
    regid_t           dst;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic [CNT_W-1:0] cntd;
    logic [CNT_W-1:0] new_cnt;
    logic             src1_used;
    logic             src2_used;
    logic             dst_used;
    logic             src1_hz;
    logic             src2_hz;
    logic             waw_hz;
    logic             flush_hit;
    logic             issue_ok;
    logic             set_en;
    logic [1:0]       hazard_src;

    assign op   = sb.instr.op;
    assign src1 = sb.instr.fields.r.src1;
    assign src2 = sb.instr.fields.r.src2;
    assign dst  = sb.instr.fields.r.dst;

    always_comb begin
        cnt1 = rd1_cnt[sb.thread];
        cnt2 = rd2_cnt[sb.thread];
        cntd = rd3_cnt[sb.thread];

        case (lat_class(op))
            LAT_ALU: new_cnt = ALU_CNT;
            LAT_MUL: new_cnt = MUL_CNT;
            LAT_MEM: new_cnt = LD_PEND;
            default: new_cnt = '0;
        endcase

        src1_used = has_src1(op) && !(ZERO_REG != 0 && src1 == '0);
        src2_used = has_src2(op) && !(ZERO_REG != 0 && src2 == '0);
        dst_used  = has_dst(op)  && !(ZERO_REG != 0 && dst  == '0);

        // A count of 1 means the value arrives on the forwarding path this
        // cycle; LD_PEND is never 1 so loads are never forwarded.
        src1_hz = src1_used && cnt1 != '0 && !(BYPASS_EN != 0 && cnt1 == ONE);
        src2_hz = src2_used && cnt2 != '0 && !(BYPASS_EN != 0 && cnt2 == ONE);
        // Block a write that would retire before an older in-flight write
        waw_hz  = dst_used && (cntd > new_cnt || cntd == LD_PEND);

        flush_hit = sb.flush_en && sb.flush_thread == sb.thread;
        issue_ok  = sb.valid_in && !sb.fetch_miss && !rst && !flush_hit
                    && !src1_hz && !src2_hz && !waw_hz;
        set_en    = issue_ok && dst_used;

        hazard_src = 2'b00;
        if (sb.valid_in && !rst && !issue_ok) begin
            if (src1_hz)
                hazard_src = 2'b01;
            else if (src2_hz)
                hazard_src = 2'b10;
            else if (waw_hz)
                hazard_src = 2'b11;
        end
    end

    for (genvar t = 0; t < NTHREADS; t++) begin : g_bank
        hzu_sb_bank #(
            .CNT_W (CNT_W)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .dec_en     (1'b1),
            .clr_all    (sb.flush_en && sb.flush_thread == threadid_t'(t)),
            .clr_ld_en  (sb.wb_en && sb.wb_thread == threadid_t'(t)),
            .clr_ld_idx (sb.wb_reg),
            .set_en     (set_en && sb.thread == threadid_t'(t)),
            .set_idx    (dst),
            .set_val    (new_cnt),
            .rd1_idx    (src1),
            .rd2_idx    (src2),
            .rd3_idx    (dst),
            .rd1_cnt    (rd1_cnt[t]),
            .rd2_cnt    (rd2_cnt[t]),
            .rd3_cnt    (rd3_cnt[t]),
            .busy       (bank_busy[t])
        );
    end

    assign sb.issue_ok     = issue_ok;
    assign sb.hazard_src   = hazard_src;
    assign sb.busy_threads = bank_busy;

endmodule
`default_nettype wire
